// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings shared by the initiator and the RAM/peripheral responders
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;
  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000
  } hburst_e;
  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;
  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;
endpackage

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: command/response port plus AHB-Lite bus signals of the initiator
//   master modport: drives cmd_ready, rsp_*, haddr/htrans/hwrite/hsize/hburst/hprot/hmastlock/hwdata
//   slave modport:  drives cmd_valid/write/addr/size/wdata, hrdata, hready, hresp
interface ahb_lite_master_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [31:0]           cmd_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hmastlock;
  logic [31:0]           hwdata;
  logic [31:0]           hrdata;
  logic                  hready;
  logic                  hresp;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata
  );
endinterface

// File: rtl/ahb_lite_align_check.sv
// ahb_lite_align_check: flags unsupported sizes and misaligned half/word addresses
//   addr_i: two address LSBs, size_i: HSIZE encoding, illegal_o: command must be rejected
module ahb_lite_align_check
  import ahb_pkg::*;
(
  input  logic [1:0] addr_i,
  input  logic [2:0] size_i,
  output logic       illegal_o
);
  assign illegal_o = (size_i > HSIZE_WORD) |
                     ((size_i == HSIZE_HALF) & addr_i[0]) |
                     ((size_i == HSIZE_WORD) & (|addr_i));
endmodule

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-outstanding pipelined AHB-Lite initiator with in-order responses
//   hclk/hresetn: bus clock and async active-low reset
//   bus (master modport): valid/ready command in, one-cycle response pulse out, AHB-Lite bus
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input logic               hclk,
  input logic               hresetn,
  ahb_lite_master_if.master bus
);
  logic                  a_valid_q, a_valid_d, a_rej_q, a_rej_d, a_write_q, a_write_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic [2:0]            a_size_q, a_size_d;
  logic [31:0]           a_wdata_q, a_wdata_d;
  logic                  d_valid_q, d_valid_d, d_write_q, d_write_d;
  logic [31:0]           d_wdata_q, d_wdata_d;
  logic                  err_q, err_d;
  htrans_e               htrans_q, htrans_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  illegal, a_mv, accept, d_load, d_done, rej_retire;
  ahb_lite_align_check u_align (
    .addr_i    (bus.cmd_addr[1:0]),
    .size_i    (bus.cmd_size),
    .illegal_o (illegal)
  );
  always_comb begin
    // A may be vacated: empty, or a legal transfer whose address phase ends, or a
    // rejected command once every older transfer has left D
    a_mv        = ~err_q & (~a_valid_q | (bus.hready & (~a_rej_q | ~d_valid_q)));
    accept      = a_mv & bus.cmd_valid;
    d_load      = a_mv & a_valid_q & ~a_rej_q;
    d_done      = d_valid_q & bus.hready;
    rej_retire  = a_mv & a_valid_q & a_rej_q;
    a_valid_d   = a_mv ? accept : a_valid_q;
    a_rej_d     = a_mv ? accept & illegal : a_rej_q;
    a_addr_d    = accept ? bus.cmd_addr : a_addr_q;
    a_write_d   = accept ? bus.cmd_write : a_write_q;
    a_size_d    = accept ? bus.cmd_size : a_size_q;
    a_wdata_d   = accept ? bus.cmd_wdata : a_wdata_q;
    d_valid_d   = d_load | (d_valid_q & ~bus.hready);
    d_write_d   = d_load ? a_write_q : d_write_q;
    d_wdata_d   = d_load ? a_wdata_q : d_wdata_q;
    // first ERROR cycle cancels the pending address phase until the second cycle ends
    err_d       = (bus.hresp == HRESP_ERROR) & ~bus.hready & d_valid_q;
    htrans_d    = (a_valid_d & ~a_rej_d & ~err_d) ? HTRANS_NONSEQ : HTRANS_IDLE;
    rsp_valid_d = d_done | rej_retire;
    rsp_err_d   = d_done ? bus.hresp : rej_retire;
    rsp_rdata_d = (d_done & ~d_write_q & ~bus.hresp) ? bus.hrdata : '0;
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_valid_q   <= 1'b0;
      a_rej_q     <= 1'b0;
      a_write_q   <= 1'b0;
      a_addr_q    <= '0;
      a_size_q    <= '0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      err_q       <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_rej_q     <= a_rej_d;
      a_write_q   <= a_write_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      err_q       <= err_d;
      htrans_q    <= htrans_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign bus.cmd_ready = hresetn & a_mv;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.haddr     = a_addr_q;
  assign bus.htrans    = htrans_q;
  assign bus.hwrite    = a_write_q;
  assign bus.hsize     = a_size_q;
  assign bus.hburst    = HBURST_SINGLE;
  assign bus.hprot     = HPROT_VAL;
  assign bus.hmastlock = 1'b0;
  assign bus.hwdata    = d_wdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed self-checking bench with a small memory responder
module tb_ahb_lite_master;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  int tot_cnt = 0;
  int fail_cnt = 0;
  logic [31:0] mem [16];
  logic [31:0] dp_addr;
  logic dp_act, dp_write;
  logic [31:0] rd_exp [4];
  always #5 hclk = ~hclk;
  ahb_lite_master_if #(.ADDR_WIDTH(32)) bus ();
  ahb_lite_master #(.ADDR_WIDTH(32), .HPROT_VAL(4'b0011)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );
  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_act   <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (bus.hready) begin
      if (dp_act && dp_write) mem[dp_addr[5:2]] <= bus.hwdata;
      dp_act   <= (bus.htrans == 2'b10);
      dp_write <= bus.hwrite;
      dp_addr  <= bus.haddr;
    end
  end
  assign bus.hrdata = (dp_act && !dp_write) ? mem[dp_addr[5:2]] : 32'h0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge hclk);
    #1;
  endtask
  task automatic cmd(input logic v, input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_wdata = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rd_exp = '{32'h1234_5678, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    cmd(0, 0, 0, 0, 0);
    bus.hready = 1'b1;
    bus.hresp  = 1'b0;
    #2;
    chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 0);
    chk("rst_htrans", {30'b0, bus.htrans}, 0);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    chk("rst_haddr", bus.haddr, 0);
    chk("rst_hwdata", bus.hwdata, 0);
    chk("rst_consts", {22'b0, bus.hburst, bus.hprot, bus.hmastlock, bus.hsize}, {22'b0, 3'b000, 4'b0011, 1'b0, 3'b000});
    step();
    step();
    hresetn = 1'b1;
    #1;
    chk("post_rst_cmd_ready", {31'b0, bus.cmd_ready}, 1);
    // write then read back the same word
    cmd(1, 1, 32'h100, 3'd2, 32'h1234_5678);
    step();
    chk("wr_htrans", {30'b0, bus.htrans}, 2);
    chk("wr_haddr", bus.haddr, 32'h100);
    chk("wr_hwrite", {31'b0, bus.hwrite}, 1);
    cmd(1, 0, 32'h100, 3'd2, 0);
    step();
    chk("rd_htrans", {30'b0, bus.htrans}, 2);
    chk("rd_hwrite", {31'b0, bus.hwrite}, 0);
    chk("wr_hwdata", bus.hwdata, 32'h1234_5678);
    chk("wr_rsp_early", {31'b0, bus.rsp_valid}, 0);
    cmd(0, 0, 0, 0, 0);
    step();
    chk("wr_rsp_valid", {31'b0, bus.rsp_valid}, 1);
    chk("wr_rsp_err", {31'b0, bus.rsp_err}, 0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    step();
    chk("rd_rsp_valid", {31'b0, bus.rsp_valid}, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("rd_rsp_err", {31'b0, bus.rsp_err}, 0);
    step();
    chk("rd_rsp_single", {31'b0, bus.rsp_valid}, 0);
    // four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      cmd(1, 0, 32'h100 + 32'(4 * i), 3'd2, 0);
      step();
      chk("b2b_htrans", {30'b0, bus.htrans}, 2);
      chk("b2b_haddr", bus.haddr, 32'h100 + 32'(4 * i));
      chk("b2b_rsp_valid", {31'b0, bus.rsp_valid}, (i >= 2) ? 1 : 0);
      if (i >= 2) chk("b2b_rdata", bus.rsp_rdata, rd_exp[i - 2]);
    end
    cmd(0, 0, 0, 0, 0);
    step();
    chk("b2b_idle", {30'b0, bus.htrans}, 0);
    chk("b2b_rsp2_valid", {31'b0, bus.rsp_valid}, 1);
    chk("b2b_rdata2", bus.rsp_rdata, rd_exp[2]);
    step();
    chk("b2b_rsp3_valid", {31'b0, bus.rsp_valid}, 1);
    chk("b2b_rdata3", bus.rsp_rdata, rd_exp[3]);
    step();
    chk("b2b_rsp_end", {31'b0, bus.rsp_valid}, 0);
    // three writes, two wait states on the second
    cmd(1, 1, 32'h110, 3'd2, 32'hB1B1_B1B1);
    step();
    cmd(1, 1, 32'h114, 3'd2, 32'hB2B2_B2B2);
    step();
    cmd(1, 1, 32'h118, 3'd2, 32'hB3B3_B3B3);
    step();
    cmd(0, 0, 0, 0, 0);
    bus.hready = 1'b0;
    #1;
    chk("ws1_haddr", bus.haddr, 32'h118);
    chk("ws1_hwdata", bus.hwdata, 32'hB2B2_B2B2);
    chk("ws1_cmd_ready", {31'b0, bus.cmd_ready}, 0);
    chk("ws1_rsp_w1", {31'b0, bus.rsp_valid, bus.rsp_err}, 2);
    step();
    chk("ws2_haddr", bus.haddr, 32'h118);
    chk("ws2_hwdata", bus.hwdata, 32'hB2B2_B2B2);
    chk("ws2_cmd_ready", {31'b0, bus.cmd_ready}, 0);
    chk("ws2_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    step();
    bus.hready = 1'b1;
    #1;
    chk("ws3_haddr", bus.haddr, 32'h118);
    chk("ws3_hwdata", bus.hwdata, 32'hB2B2_B2B2);
    chk("ws3_cmd_ready", {31'b0, bus.cmd_ready}, 1);
    chk("ws3_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    step();
    chk("ws_rsp_w2", {31'b0, bus.rsp_valid, bus.rsp_err}, 2);
    chk("ws_hwdata_w3", bus.hwdata, 32'hB3B3_B3B3);
    chk("ws_idle", {30'b0, bus.htrans}, 0);
    step();
    chk("ws_rsp_w3", {31'b0, bus.rsp_valid, bus.rsp_err}, 2);
    step();
    chk("ws_rsp_end", {31'b0, bus.rsp_valid}, 0);
    // ERROR on the first of two reads
    cmd(1, 0, 32'h120, 3'd2, 0);
    step();
    cmd(1, 0, 32'h124, 3'd2, 0);
    step();
    cmd(0, 0, 0, 0, 0);
    bus.hresp  = 1'b1;
    bus.hready = 1'b0;
    #1;
    chk("err1_htrans", {30'b0, bus.htrans}, 2);
    chk("err1_haddr", bus.haddr, 32'h124);
    step();
    bus.hready = 1'b1;
    #1;
    chk("err2_htrans", {30'b0, bus.htrans}, 0);
    chk("err2_cmd_ready", {31'b0, bus.cmd_ready}, 0);
    chk("err2_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    step();
    bus.hresp = 1'b0;
    chk("err_rsp", {31'b0, bus.rsp_valid, bus.rsp_err}, 3);
    chk("err_rdata", bus.rsp_rdata, 0);
    chk("reissue_htrans", {30'b0, bus.htrans}, 2);
    chk("reissue_haddr", bus.haddr, 32'h124);
    step();
    chk("reissue_idle", {30'b0, bus.htrans}, 0);
    chk("reissue_no_rsp", {31'b0, bus.rsp_valid}, 0);
    step();
    chk("reissue_rsp", {31'b0, bus.rsp_valid, bus.rsp_err}, 2);
    chk("reissue_rdata", bus.rsp_rdata, 32'hA000_0009);
    step();
    chk("reissue_end", {31'b0, bus.rsp_valid}, 0);
    // misaligned word behind a legal read
    cmd(1, 0, 32'h104, 3'd2, 0);
    step();
    cmd(1, 0, 32'h102, 3'd2, 0);
    step();
    cmd(0, 0, 0, 0, 0);
    chk("rej_htrans1", {30'b0, bus.htrans}, 0);
    chk("rej_cmd_ready", {31'b0, bus.cmd_ready}, 0);
    step();
    chk("rej_htrans2", {30'b0, bus.htrans}, 0);
    chk("rej_prev_rsp", {31'b0, bus.rsp_valid, bus.rsp_err}, 2);
    chk("rej_prev_rdata", bus.rsp_rdata, 32'hA000_0001);
    step();
    chk("rej_htrans3", {30'b0, bus.htrans}, 0);
    chk("rej_rsp", {31'b0, bus.rsp_valid, bus.rsp_err}, 3);
    chk("rej_rdata", bus.rsp_rdata, 0);
    step();
    chk("rej_end", {31'b0, bus.rsp_valid}, 0);
    // reset during a wait-stated data phase
    cmd(1, 1, 32'h130, 3'd2, 32'hC0C0_C0C0);
    step();
    cmd(1, 0, 32'h134, 3'd2, 0);
    step();
    cmd(0, 0, 0, 0, 0);
    bus.hready = 1'b0;
    step();
    chk("mid_htrans", {30'b0, bus.htrans}, 2);
    #2;
    hresetn = 1'b0;
    #1;
    chk("mid_rst_htrans", {30'b0, bus.htrans}, 0);
    chk("mid_rst_rsp", {31'b0, bus.rsp_valid}, 0);
    chk("mid_rst_cmd_ready", {31'b0, bus.cmd_ready}, 0);
    bus.hready = 1'b1;
    step();
    hresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_rsp", {31'b0, bus.rsp_valid}, 0);
      chk("post_rst_htrans", {30'b0, bus.htrans}, 0);
    end
    chk("post_rst_ready", {31'b0, bus.cmd_ready}, 1);
    $display("%0d/%0d checks passed", tot_cnt - fail_cnt, tot_cnt);
    $finish;
  end
endmodule
